// File: rtl/mem_wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_pkg
// Shared constants for the MEM/WB pipeline stage.
//   DATA_W_DEF      default data path width
//   REG_ADDR_W_DEF  default register-file address width
//   CNT_W_DEF       default retired-instruction counter width
//   REG_ZERO        architectural zero register (never written)
//   WB_SEL_ALU/MEM  write-back source select encodings
// ---------------------------------------------------------------------------
package mem_wb_stage_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int CNT_W_DEF      = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

endpackage : mem_wb_stage_pkg

// File: rtl/pipe_reg.sv
// ---------------------------------------------------------------------------
// pipe_reg
// Generic W-bit pipeline register.
//   Clk    rising-edge clock
//   Rst_n  asynchronous active-low reset, clears Q to 0
//   En     load D on the next edge
//   Clr    clear Q to 0 on the next edge (wins over En)
//   D      next value
//   Q      registered value
// ---------------------------------------------------------------------------
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         En,
    input  logic         Clr,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q
);

    logic [W-1:0] r_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_q <= '0;
        end else if (Clr) begin
            r_q <= '0;
        end else if (En) begin
            r_q <= D;
        end
    end

    assign Q = r_q;

endmodule : pipe_reg

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
// MEM/WB pipeline register with write-back select and retired counter.
// Inputs (from the memory stage):
//   Clk, Rst_n          clock, asynchronous active-low reset
//   ValidIn             slot holds a real instruction
//   StallIn / FlushIn   hold the stage / insert a bubble (flush wins)
//   RegWriteIn          register-file write enable
//   MemToRegIn          1 = write back load data, 0 = ALU result
//   ALUIn, DataMemIn    ALU result and load data
//   DestinationRegIn    destination register number
// Outputs (to register file and forwarding bus):
//   ValidOut, RegWriteOut, DestinationRegOut, WriteDataOut
//   RetiredCountOut     instructions accepted into the stage (wraps)
// ---------------------------------------------------------------------------
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  ValidIn,
    input  logic                  StallIn,
    input  logic                  FlushIn,
    input  logic                  RegWriteIn,
    input  logic                  MemToRegIn,
    input  logic [DATA_W-1:0]     ALUIn,
    input  logic [DATA_W-1:0]     DataMemIn,
    input  logic [REG_ADDR_W-1:0] DestinationRegIn,
    output logic                  ValidOut,
    output logic                  RegWriteOut,
    output logic [REG_ADDR_W-1:0] DestinationRegOut,
    output logic [DATA_W-1:0]     WriteDataOut,
    output logic [CNT_W-1:0]      RetiredCountOut
);

    localparam int BUNDLE_W = 3 + REG_ADDR_W + 2 * DATA_W;

    logic                  w_reg_write_qual;
    logic                  w_load;
    logic [BUNDLE_W-1:0]   w_bundle_d;
    logic [BUNDLE_W-1:0]   w_bundle_q;
    logic                  w_valid_q;
    logic                  w_reg_write_q;
    logic                  w_mem_to_reg_q;
    logic [REG_ADDR_W-1:0] w_dest_q;
    logic [DATA_W-1:0]     w_alu_q;
    logic [DATA_W-1:0]     w_mem_q;
    logic [CNT_W-1:0]      r_retired_cnt;

    // Qualify the write enable before capture so the register file never
    // sees a write from a bubble or to the zero register.
    assign w_reg_write_qual = RegWriteIn & ValidIn &
                              (DestinationRegIn != REG_ADDR_W'(REG_ZERO));

    assign w_load = ~FlushIn & ~StallIn;

    assign w_bundle_d = {ValidIn, w_reg_write_qual, MemToRegIn,
                         DestinationRegIn, ALUIn, DataMemIn};

    pipe_reg #(
        .W (BUNDLE_W)
    ) u_bundle_reg (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .En    (~StallIn),
        .Clr   (FlushIn),
        .D     (w_bundle_d),
        .Q     (w_bundle_q)
    );

    assign {w_valid_q, w_reg_write_q, w_mem_to_reg_q,
            w_dest_q, w_alu_q, w_mem_q} = w_bundle_q;

    // Counter only advances when a real instruction is actually accepted;
    // flushes and stalls both hold it. Wraps modulo 2^CNT_W.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_retired_cnt <= '0;
        end else if (w_load && ValidIn) begin
            r_retired_cnt <= r_retired_cnt + CNT_W'(1);
        end
    end

    assign ValidOut          = w_valid_q;
    assign RegWriteOut       = w_reg_write_q;
    assign DestinationRegOut = w_dest_q;
    assign WriteDataOut      = (w_mem_to_reg_q == WB_SEL_MEM) ? w_mem_q : w_alu_q;
    assign RetiredCountOut   = r_retired_cnt;

endmodule : mem_wb_stage
